// File: rtl/shreg_sipo_rx_pkg.sv
// rtl/shreg_sipo_rx_pkg.sv - shared constants for the SIPO receiver (optional macro SHREG_SIPO_PARITY_EN)
package shreg_pkg;

  localparam int DEF_WIDTH = 8;

`ifdef SHREG_SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Extra bits per frame beyond the data word (the trailing even-parity bit).
  localparam int PAR_BITS = PARITY_EN ? 1 : 0;

  function automatic int cnt_w(input int width);
    return $clog2(width + PAR_BITS);
  endfunction

endpackage

// File: rtl/shreg_sipo_rx_if.sv
// rtl/shreg_sipo_rx_if.sv - valid/ready word output bundle of the SIPO receiver
interface shreg_sipo_rx_if
  import shreg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/shreg_sipo_rx_sipo_shifter.sv
// rtl/shreg_sipo_rx_sipo_shifter.sv - shift register and bit counter, strobes done with the completed word
// Optional macro SHREG_SIPO_PARITY_EN adds a trailing even-parity bit to each frame.
module sipo_shifter
  import shreg_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [CW-1:0]    bit_cnt,
  output logic             done,
  output logic [WIDTH-1:0] word,
  output logic             par_bad
);
  localparam int FRAME = WIDTH + PAR_BITS;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic             last;
  logic             shift_en;

  always_comb begin
    sh_next = '0;
    if (MSB_FIRST) sh_next = {sh[WIDTH-2:0], sin};
    else           sh_next = {sin, sh[WIDTH-1:1]};
  end

  assign last = (bit_cnt == CW'(FRAME - 1));
  assign done = sin_vld && last;

`ifdef SHREG_SIPO_PARITY_EN
  // The parity bit never enters the shift register; it is only checked.
  assign shift_en = sin_vld && !last;
  assign word     = sh;
  assign par_bad  = ^{sh, sin};
`else
  // The final data bit bypasses sh so the word is ready at its own edge.
  assign shift_en = sin_vld;
  assign word     = sh_next;
  assign par_bad  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) sh <= sh_next;
      if (sin_vld)  bit_cnt <= last ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shreg_sipo_rx.sv
// rtl/shreg_sipo_rx.sv - serial-in/parallel-out receiver with single-entry holding register and sticky overrun
// Optional macro SHREG_SIPO_PARITY_EN enables the trailing even-parity bit and par_err.
module shreg_sipo_rx
  import shreg_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            sin,
  input  logic            sin_vld,
  shreg_sipo_rx_if.master ob,
  output logic            busy,
  output logic [CW-1:0]   bit_cnt,
  output logic            overrun,
  output logic            par_err
);
  logic             done;
  logic [WIDTH-1:0] word;
  logic             par_bad;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             perr_q;
  logic             ovr_q;
  logic             load;

  sipo_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .sin     (sin),
    .sin_vld (sin_vld),
    .bit_cnt (bit_cnt),
    .done    (done),
    .word    (word),
    .par_bad (par_bad)
  );

  // A new word may enter only when the slot is empty or is being drained this edge.
  assign load = done && (!valid_q || ob.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (clr) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= word;
        valid_q <= 1'b1;
        perr_q  <= par_bad;
      end else if (valid_q && ob.out_ready) begin
        valid_q <= 1'b0;
      end
      if (done && !load) ovr_q <= 1'b1;
    end
  end

  assign ob.out_data  = data_q;
  assign ob.out_valid = valid_q;
  assign busy         = (bit_cnt != '0);
  assign overrun      = ovr_q;

`ifdef SHREG_SIPO_PARITY_EN
  assign par_err = perr_q;
`else
  logic unused_par;
  assign unused_par = perr_q ^ par_bad;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_shreg_sipo_rx.sv
// tb/tb_shreg_sipo_rx.sv - randomized self-checking bench for shreg_sipo_rx, both bit orders side by side
module tb_shreg_sipo_rx;
  import shreg_pkg::*;

  localparam int W     = 8;
  localparam int CW    = cnt_w(W);
  localparam int FRAME = W + PAR_BITS;

  logic clk = 1'b0;
  logic rst_n, clr, sin, sin_vld, rdy;
  logic busy1, busy0, ovr1, ovr0, perr1, perr0;
  logic [CW-1:0] cnt1, cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  shreg_sipo_rx_if #(.WIDTH(W)) ob1 ();
  shreg_sipo_rx_if #(.WIDTH(W)) ob0 ();
  assign ob1.out_ready = rdy;
  assign ob0.out_ready = rdy;

  shreg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .sin_vld(sin_vld), .ob(ob1),
    .busy(busy1), .bit_cnt(cnt1), .overrun(ovr1), .par_err(perr1));

  shreg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .sin_vld(sin_vld), .ob(ob0),
    .busy(busy0), .bit_cnt(cnt0), .overrun(ovr0), .par_err(perr0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 1 = MSB-first receiver, index 0 = LSB-first receiver.
  bit             fq[$];
  logic [W-1:0]   m_data[2];
  bit             m_valid[2];
  bit             m_ovr[2];
  bit             m_perr[2];
  logic [W-1:0]   mw[2];
  bit             m_done;
  bit             m_pe;

  task automatic model_reset();
    fq.delete();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = '0; m_valid[k] = 0; m_ovr[k] = 0; m_perr[k] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      m_done = 0;
      m_pe   = 0;
      if (sin_vld) begin
        fq.push_back(sin);
        if (fq.size() == FRAME) begin
          m_done = 1;
          for (int i = 0; i < W; i++) begin
            mw[1][W-1-i] = fq[i];
            mw[0][i]     = fq[i];
          end
          if (PARITY_EN) m_pe = (^mw[1]) ^ fq[W];
          fq.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (m_done && (!m_valid[k] || rdy)) begin
          m_data[k] = mw[k]; m_valid[k] = 1; m_perr[k] = m_pe;
        end else if (m_done) begin
          m_ovr[k] = 1;
        end else if (m_valid[k] && rdy) begin
          m_valid[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("data1",  ob1.out_data,  m_data[1]);
      chk("valid1", ob1.out_valid, m_valid[1]);
      chk("ovr1",   ovr1,          m_ovr[1]);
      chk("perr1",  perr1,         m_perr[1]);
      chk("cnt1",   cnt1,          fq.size());
      chk("busy1",  busy1,         fq.size() != 0);
      chk("data0",  ob0.out_data,  m_data[0]);
      chk("valid0", ob0.out_valid, m_valid[0]);
      chk("ovr0",   ovr0,          m_ovr[0]);
      chk("perr0",  perr0,         m_perr[0]);
      chk("cnt0",   cnt0,          fq.size());
      chk("busy0",  busy0,         fq.size() != 0);
    end
  end

  task automatic cyc(input logic s, input logic v);
    sin = s; sin_vld = v;
    @(posedge clk); #1;
    sin_vld = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit msb, input bit pbit,
                            input bit gap, input bit rdy_last);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = msb ? w[W-1-i] : w[i];
      if (rdy_last && i == W-1 && !PARITY_EN) rdy = 1;
      cyc(b, 1);
      if (gap && i != W-1) cyc(1'($urandom_range(0, 1)), 0);
    end
    if (PARITY_EN) begin
      if (gap) cyc(1'($urandom_range(0, 1)), 0);
      if (rdy_last) rdy = 1;
      cyc(pbit, 1);
    end
  endtask

  initial begin
    rst_n = 0; clr = 0; sin = 0; sin_vld = 0; rdy = 1;
    #2;
    chk("rst_valid1", ob1.out_valid, 0);
    chk("rst_data1",  ob1.out_data,  0);
    chk("rst_cnt1",   cnt1,          0);
    @(posedge clk); #1;
    rst_n = 1;

    // partial frame discarded by asynchronous reset between edges
    cyc(1, 1); cyc(0, 1); cyc(1, 1);
    chk("pre_rst_cnt", cnt1, 3);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_cnt",   cnt1,          0);
    chk("mid_rst_busy",  busy1,         0);
    chk("mid_rst_valid", ob1.out_valid, 0);
    chk("mid_rst_data",  ob1.out_data,  0);
    #2 rst_n = 1;
    @(posedge clk); #1;

    // back-to-back FE, MSB first
    rdy = 1;
    chk("fe_pre_valid", ob1.out_valid, 0);
    send_frame(8'hFE, 1, ^8'hFE, 0, 0);
    chk("fe_data1",  ob1.out_data,  8'hFE);
    chk("fe_model1", m_data[1],     8'hFE);
    chk("fe_valid1", ob1.out_valid, 1);
    chk("fe_data0",  ob0.out_data,  8'h7F);
    cyc(0, 0);
    chk("fe_drain", ob1.out_valid, 0);

    // same word with idle gaps
    send_frame(8'hFE, 1, ^8'hFE, 1, 0);
    chk("gap_data1", ob1.out_data, 8'hFE);
    cyc(0, 0);

    // backpressure: second word dropped, overrun sticky until clr
    rdy = 0;
    send_frame(8'hA5, 1, ^8'hA5, 0, 0);
    send_frame(8'h3C, 1, ^8'h3C, 0, 0);
    chk("bp_data1",  ob1.out_data,  8'hA5);
    chk("bp_ovr1",   ovr1,          1);
    chk("bp_model",  m_ovr[1],      1);
    rdy = 1;
    cyc(0, 0);
    chk("bp_valid1", ob1.out_valid, 0);
    do_clr();
    chk("bp_clr_ovr", ovr1, 0);

    // completion coinciding with a transfer
    rdy = 0;
    send_frame(8'hA5, 1, ^8'hA5, 0, 0);
    send_frame(8'h3C, 1, ^8'h3C, 0, 1);
    chk("co_data1",  ob1.out_data,  8'h3C);
    chk("co_valid1", ob1.out_valid, 1);
    chk("co_ovr1",   ovr1,          0);
    cyc(0, 0);

    // LSB-first receiver: bits 0,1,1,1,1,1,1,1
    send_frame(8'hFE, 0, 1'b0, 0, 0);
    chk("lsb_data0",  ob0.out_data, 8'hFE);
    chk("lsb_model0", m_data[0],    8'hFE);
    chk("lsb_perr0",  perr0,        PARITY_EN ? 1 : 0);
    cyc(0, 0);
    if (PARITY_EN) begin
      send_frame(8'hFE, 0, 1'b1, 0, 0);
      chk("lsb_perr_ok", perr0, 0);
      cyc(0, 0);
    end

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      sin     = 1'($urandom_range(0, 1));
      sin_vld = ($urandom_range(0, 9) < 7);
      rdy     = ($urandom_range(0, 1) == 1);
      clr     = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    clr = 0; sin_vld = 0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
